// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the
// instruction-fetch and load/store requesters.  Each access runs
// IDLE -> ISSUE -> WAIT -> RESP and ends with a one-cycle ready pulse.
// Data wins over fetch by default; define MEM_ARB_ROUND_ROBIN_EN to alternate
// grants when both requesters collide.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned BE_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  gnt_data_q, gnt_data_d;
    logic                  pick_data;
    logic                  mem_we_d;
    logic [BE_W-1:0]       mem_be_d;
    logic [DATA_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_data_q;

    // On a collision grant the requester that did not win last time
    assign pick_data = d_req && (!if_req || !last_data_q);

    // Remember which requester received the most recent grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_data_q <= 1'b0;
        end else if (state_q == IDLE && (if_req || d_req)) begin
            last_data_q <= pick_data;
        end
    end
`else
    // Load/store belongs to the instruction already in flight, so it wins
    assign pick_data = d_req;
`endif

    // Next-state, access latch and read-data capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_data_d  = gnt_data_q;
        mem_we_d    = mem_we;
        mem_be_d    = mem_be;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    gnt_data_d = pick_data;
                    if (pick_data) begin
                        mem_we_d    = d_we;
                        mem_be_d    = d_be;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = 4'hF;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (gnt_data_q) begin
                        if (!mem_we) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_data_q <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_data_q <= gnt_data_d;
            mem_en     <= (state_d == ISSUE);
            mem_we     <= mem_we_d;
            mem_be     <= mem_be_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            if_rdata   <= if_rdata_d;
            d_rdata    <= d_rdata_d;
            if_ready   <= (state_d == RESP) && !gnt_data_d;
            d_ready    <= (state_d == RESP) && gnt_data_d;
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single accesses against a
// latency-1 memory model, plus hand sequences for collisions, a latency-4
// instance with garbage read data and reset during WAIT.
module tb_mem_port_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 1;
    localparam int unsigned LAT4 = 4;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [DW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    logic          rst4;
    logic          if_req4;
    logic [DW-1:0] if_addr4;
    logic          if_ready4;
    logic [DW-1:0] if_rdata4;
    logic          d_req4;
    logic          d_we4;
    logic [3:0]    d_be4;
    logic [DW-1:0] d_addr4;
    logic [DW-1:0] d_wdata4;
    logic          d_ready4;
    logic [DW-1:0] d_rdata4;
    logic          mem_en4;
    logic          mem_we4;
    logic [3:0]    mem_be4;
    logic [DW-1:0] mem_addr4;
    logic [DW-1:0] mem_wdata4;
    logic [DW-1:0] mem_rdata4;
    logic          busy4;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(LAT4)) dut4 (
        .clk(clk), .rst(rst4),
        .if_req(if_req4), .if_addr(if_addr4), .if_ready(if_ready4), .if_rdata(if_rdata4),
        .d_req(d_req4), .d_we(d_we4), .d_be(d_be4), .d_addr(d_addr4), .d_wdata(d_wdata4),
        .d_ready(d_ready4), .d_rdata(d_rdata4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_be(mem_be4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 word RAM with byte enables, preloaded while in reset
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (!rst) begin
            ram[8'h04] <= 32'h00500093;
            ram[8'h40] <= 32'h11223344;
            ram[8'h41] <= 32'hCAFEF00D;
            ram[8'h10] <= 32'h13579BDF;
            mem_rdata  <= '0;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we && mem_be[b]) begin
                    ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    typedef struct {
        logic          ifr;
        logic [DW-1:0] ia;
        logic          dr;
        logic          we;
        logic [3:0]    be;
        logic [DW-1:0] da;
        logic [DW-1:0] wd;
        logic          gnt_data;
        logic          e_we;
        logic [3:0]    e_be;
        logic [DW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [DW-1:0] e_if_rdata;
        logic [DW-1:0] e_d_rdata;
    } vec_t;

    vec_t vec [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one access, check the issue cycle, latency, ready and read data
    task automatic run_vec(input vec_t v, input string tag);
        int ready_at;
        int en_cnt;
        if_req  = v.ifr; if_addr = v.ia;
        d_req   = v.dr;  d_we    = v.we; d_be = v.be; d_addr = v.da; d_wdata = v.wd;
        ready_at = 0;
        en_cnt   = 0;
        for (int i = 1; i <= 12 && ready_at == 0; i++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (i == 1) begin
                chk({tag, " issue en"}, 32'(mem_en), 32'd1);
                chk({tag, " issue busy"}, 32'(busy), 32'd1);
                chk({tag, " issue we"}, 32'(mem_we), 32'(v.e_we));
                chk({tag, " issue be"}, 32'(mem_be), 32'(v.e_be));
                chk({tag, " issue addr"}, mem_addr, v.e_addr);
                chk({tag, " issue wdata"}, mem_wdata, v.e_wdata);
            end
            if (i == 2) begin
                chk({tag, " wait en"}, 32'(mem_en), 32'd0);
                chk({tag, " wait addr held"}, mem_addr, v.e_addr);
            end
            if (if_ready || d_ready) begin
                ready_at = i;
                chk({tag, " d_ready"}, 32'(d_ready), 32'(v.gnt_data));
                chk({tag, " if_ready"}, 32'(if_ready), 32'(!v.gnt_data));
            end
        end
        chk({tag, " latency"}, 32'(ready_at), 32'(LAT + 2));
        chk({tag, " en count"}, 32'(en_cnt), 32'd1);
        chk({tag, " if_rdata"}, if_rdata, v.e_if_rdata);
        chk({tag, " d_rdata"}, d_rdata, v.e_d_rdata);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " ready one cycle"}, 32'(if_ready | d_ready), 32'd0);
    endtask

    // Fetch 0x40 and load 0x104 together; check order and back-to-back spacing
    task automatic both_req(input logic data_first, input string tag);
        int   t1;
        int   t2;
        logic first_d;
        if_req = 1'b1; if_addr = 32'h40;
        d_req  = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h104; d_wdata = '0;
        t1 = 0; t2 = 0; first_d = 1'b0;
        for (int i = 1; i <= 20 && t1 == 0; i++) begin
            @(negedge clk);
            if (if_ready || d_ready) begin
                t1      = i;
                first_d = d_ready;
            end
        end
        chk({tag, " first is data"}, 32'(first_d), 32'(data_first));
        chk({tag, " first latency"}, 32'(t1), 32'(LAT + 2));
        if (first_d) d_req = 1'b0;
        else         if_req = 1'b0;
        for (int i = 1; i <= 20 && t2 == 0; i++) begin
            @(negedge clk);
            if (if_ready || d_ready) t2 = i;
        end
        chk({tag, " spacing"}, 32'(t2), 32'(LAT + 3));
        chk({tag, " second is data"}, 32'(d_ready), 32'(!data_first));
        if_req = 1'b0;
        d_req  = 1'b0;
        chk({tag, " if_rdata"}, if_rdata, 32'h13579BDF);
        chk({tag, " d_rdata"}, d_rdata, 32'hCAFEF00D);
        @(negedge clk);
    endtask

    // Fetch on the latency-4 instance; returns the cycle ready appeared
    task automatic fetch4(input logic [DW-1:0] addr, input logic [DW-1:0] good,
                          input logic [DW-1:0] prev, input string tag);
        int ready_at;
        if_req4 = 1'b1; if_addr4 = addr; mem_rdata4 = 32'hBAD0BAD0;
        ready_at = 0;
        for (int i = 1; i <= 16 && ready_at == 0; i++) begin
            @(negedge clk);
            if (if_ready4) ready_at = i;
            if (i == 1) begin
                chk({tag, " issue en"}, 32'(mem_en4), 32'd1);
                chk({tag, " issue addr"}, mem_addr4, addr);
            end
            if (i == LAT4 + 1) begin
                chk({tag, " no early capture"}, if_rdata4, prev);
            end
            mem_rdata4 = (i == LAT4 + 1) ? good : (32'hBAD0BAD0 ^ 32'(i));
        end
        chk({tag, " latency"}, 32'(ready_at), 32'(LAT4 + 2));
        chk({tag, " if_rdata"}, if_rdata4, good);
        if_req4 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_cnt;
        int busy_cnt;
        logic rr_data_first;

        //           ifr ia        dr we be    da        wd            gnt we be    addr      wdata         if_rdata      d_rdata
        vec[0] = '{1'b1, 32'h10,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b0, 4'hF, 32'h10,  32'h0,        32'h00500093, 32'h0};
        vec[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF, 32'h00500093, 32'h0};
        vec[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 4'hF, 32'h100, 32'h0,        1'b1, 1'b0, 4'hF, 32'h100, 32'h0,        32'h00500093, 32'h1122BEEF};
        vec[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 4'h0, 32'h104, 32'hFFFFFFFF, 1'b1, 1'b1, 4'h0, 32'h104, 32'hFFFFFFFF, 32'h00500093, 32'h1122BEEF};
        vec[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 4'hF, 32'h104, 32'h0,        1'b1, 1'b0, 4'hF, 32'h104, 32'h0,        32'h00500093, 32'hCAFEF00D};
        vec[5] = '{1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b0, 4'hF, 32'h104, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
        vec[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 4'hF, 32'h100, 32'h0,        1'b1, 1'b0, 4'hF, 32'h100, 32'h0,        32'h13579BDF, 32'h1122BEEF};

        rst = 1'b0; rst4 = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
        if_req4 = 1'b0; if_addr4 = '0; mem_rdata4 = '0;
        d_req4 = 1'b0; d_we4 = 1'b0; d_be4 = 4'h0; d_addr4 = '0; d_wdata4 = '0;

        // Reset held with a pending fetch: everything stays at zero
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset mem_en", 32'(mem_en), 32'd0);
        chk("reset ready", 32'({if_ready, d_ready}), 32'd0);
        chk("reset mem_ctl", 32'({mem_we, mem_be}), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset if_rdata", if_rdata, 32'd0);
        chk("reset d_rdata", d_rdata, 32'd0);
        rst  = 1'b1;
        rst4 = 1'b1;

        // Release: the held fetch starts at the very next edge
        for (int k = 0; k < 6; k++) begin
            run_vec(vec[k], $sformatf("vec%0d", k));
        end

        // Collision from IDLE after a fetch grant: data goes first either way
        both_req(1'b1, "collide_a");

        // After a data grant, round-robin hands the collision to fetch
        run_vec(vec[6], "vec6");
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_data_first = 1'b0;
`else
        rr_data_first = 1'b1;
`endif
        both_req(rr_data_first, "collide_b");

        // Latency 4: garbage before the capture edge must not be taken
        fetch4(32'h20, 32'h0BADF00D, 32'h0, "lat4");

        // Reset in WAIT abandons the fetch and produces no ready
        if_req4 = 1'b1; if_addr4 = 32'h24; mem_rdata4 = 32'h12345678;
        repeat (3) @(negedge clk);
        chk("midrst busy before", 32'(busy4), 32'd1);
        rst4 = 1'b0;
        #1;
        chk("midrst busy", 32'(busy4), 32'd0);
        chk("midrst mem_addr", mem_addr4, 32'd0);
        chk("midrst if_rdata", if_rdata4, 32'd0);
        if_req4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        rdy_cnt  = 0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_ready4 || d_ready4) rdy_cnt++;
            if (busy4) busy_cnt++;
        end
        chk("midrst no ready", 32'(rdy_cnt), 32'd0);
        chk("midrst stays idle", 32'(busy_cnt), 32'd0);
        fetch4(32'h28, 32'h600D0001, 32'h0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
